// File: rtl/key_pkg.sv
// Shared constants and types for the key event scheduler and its per-key filters.
package key_pkg;

    // Event kinds carried on ev_kind
    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_LONG    = 2'd1;
    localparam logic [1:0] EV_REPEAT  = 2'd2;
    localparam logic [1:0] EV_RELEASE = 2'd3;

    // Default timing at the 190 Hz scan clock
    localparam int DEF_N_KEYS        = 4;
    localparam int DEF_STABLE_CYCLES = 6;   // ~32 ms of clean samples
    localparam int DEF_HOLD_CYCLES   = 95;  // 0.5 s until LONG
    localparam int DEF_REPEAT_CYCLES = 19;  // 0.1 s between REPEATs

    // One-deep pending event slot per key
    typedef struct packed {
        logic       full;
        logic [1:0] kind;
    } slot_t;

    // Counter width able to hold max(hold, repeat) - 1
    function automatic int cnt_width(input int hold, input int rep);
        int m;
        m = (hold > rep) ? hold : rep;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/key_filter.sv
// One key: debounce history, press-tracking FSM with hold/repeat counter,
// and the one-deep pending event slot with its sticky overflow flag.
module key_filter
    import key_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic  clk190hz,
    input  logic  rst,
    input  logic  i_press,
    input  logic  i_grant,
    input  logic  i_clr_ovf,
    output logic  o_key_down,
    output slot_t o_slot,
    output logic  o_ovf
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DOWN = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;

    logic [STABLE_CYCLES-1:0] r_hist;
    logic [STABLE_CYCLES-1:0] w_hist_next;
    logic [1:0]               r_state;
    logic [1:0]               w_state_next;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_next;
    logic                     w_post;
    logic [1:0]               w_post_kind;
    logic                     w_ovf_set;
    slot_t                    r_slot;
    logic                     r_ovf;

    // Shift the newest raw sample into the bottom of the history
    always_comb begin
        w_hist_next    = r_hist << 1;
        w_hist_next[0] = i_press;
    end

    // Debounce history register
    always_ff @(posedge clk190hz or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) r_hist <= '0;
        else     r_hist <= w_hist_next;
    end

    // Down only when the whole window is high; a single low sample drops it
    assign o_key_down = &r_hist;

    // Key FSM next state, counter and event post; release beats LONG/REPEAT
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_post       = 1'b0;
        w_post_kind  = EV_PRESS;
        case (r_state)
            ST_IDLE: begin
                if (o_key_down) begin
                    w_state_next = ST_DOWN;
                    w_post       = 1'b1;
                    w_post_kind  = EV_PRESS;
                    w_cnt_next   = '0;
                end
            end
            ST_DOWN: begin
                if (!o_key_down) begin
                    w_state_next = ST_IDLE;
                    w_post       = 1'b1;
                    w_post_kind  = EV_RELEASE;
                    w_cnt_next   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_next = ST_HELD;
                    w_post       = 1'b1;
                    w_post_kind  = EV_LONG;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!o_key_down) begin
                    w_state_next = ST_IDLE;
                    w_post       = 1'b1;
                    w_post_kind  = EV_RELEASE;
                    w_cnt_next   = '0;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_post      = 1'b1;
                    w_post_kind = EV_REPEAT;
                    w_cnt_next  = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // FSM state and counter registers
    always_ff @(posedge clk190hz or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Overwrite only counts as overflow if the old event is not leaving this cycle
    assign w_ovf_set = w_post && r_slot.full && !i_grant;

    // Pending slot: a post always lands; a grant without a post empties it
    always_ff @(posedge clk190hz or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
        end else if (w_post) begin
            r_slot.full <= 1'b1;
            r_slot.kind <= w_post_kind;
        end else if (i_grant) begin
            r_slot.full <= 1'b0;
        end
    end

    // Sticky overflow flag; a set in the same cycle as a clear wins
    always_ff @(posedge clk190hz or posedge rst) begin
        if (rst)            r_ovf <= 1'b0;
        else if (w_ovf_set) r_ovf <= 1'b1;
        else if (i_clr_ovf) r_ovf <= 1'b0;
    end

    assign o_slot = r_slot;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/key_event_scheduler.sv
// Debounces N_KEYS buttons, turns their activity into PRESS/LONG/REPEAT/RELEASE
// events and serialises them onto one valid/ready port with a round-robin arbiter.
module key_event_scheduler
    import key_pkg::*;
#(
    parameter int N_KEYS        = DEF_N_KEYS,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic                      clk190hz,
    input  logic                      rst,
    input  logic [N_KEYS-1:0]         press,
    input  logic                      ev_ready,
    input  logic                      clr_ovf,
    output logic                      ev_valid,
    output logic [$clog2(N_KEYS)-1:0] ev_key,
    output logic [1:0]                ev_kind,
    output logic [N_KEYS-1:0]         ovf,
    output logic [N_KEYS-1:0]         key_down
);

    localparam int KEY_W = $clog2(N_KEYS);

    slot_t             w_slot [N_KEYS];
    logic [N_KEYS-1:0] w_grant;
    logic              w_load;
    logic              w_found;
    logic [KEY_W-1:0]  w_sel;
    logic [KEY_W-1:0]  w_ptr_next;
    int                w_idx;

    logic              r_valid;
    logic [KEY_W-1:0]  r_key;
    logic [1:0]        r_kind;
    logic [KEY_W-1:0]  r_ptr;

    genvar g;
    generate
        for (g = 0; g < N_KEYS; g++) begin : g_key
            key_filter #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .HOLD_CYCLES   (HOLD_CYCLES),
                .REPEAT_CYCLES (REPEAT_CYCLES)
            ) u_key_filter (
                .clk190hz   (clk190hz),
                .rst        (rst),
                .i_press    (press[g]),
                .i_grant    (w_grant[g]),
                .i_clr_ovf  (clr_ovf),
                .o_key_down (key_down[g]),
                .o_slot     (w_slot[g]),
                .o_ovf      (ovf[g])
            );
        end
    endgenerate

    // Round-robin pick: first full slot at or after ptr, wrapping modulo N_KEYS
    always_comb begin
        w_load  = !r_valid || ev_ready;
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        w_grant = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            w_idx = (int'(r_ptr) + i) % N_KEYS;
            if (!w_found && w_slot[w_idx].full) begin
                w_found = 1'b1;
                w_sel   = KEY_W'(w_idx);
            end
        end
        if (w_load && w_found) w_grant[w_sel] = 1'b1;
    end

    // Pointer moves just past the grantee so that key gets lowest priority next
    assign w_ptr_next = (w_sel == KEY_W'(N_KEYS - 1)) ? '0 : w_sel + 1'b1;

    // Output register: refills when empty or when the consumer takes the event
    always_ff @(posedge clk190hz or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_key   <= '0;
            r_kind  <= EV_PRESS;
            r_ptr   <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_valid <= 1'b1;
                r_key   <= w_sel;
                r_kind  <= w_slot[w_sel].kind;
                r_ptr   <= w_ptr_next;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ev_valid = r_valid;
    assign ev_key   = r_key;
    assign ev_kind  = r_kind;

endmodule

// File: doc/key_event_scheduler.md
# key_event_scheduler

Sequences up to `N_KEYS` raw push-button inputs through per-key debounce filters and per-key press-tracking state machines. Converts each key's activity into discrete events: PRESS, LONG, REPEAT and RELEASE. Shares a single event output port between all keys with a round-robin arbiter and a valid/ready handshake. It sits between the board buttons and the lab control logic, and runs entirely in the 190 Hz scan clock domain.

## Interface
Parameters:
- `N_KEYS`, 4: number of keys (2..8).
- `STABLE_CYCLES`, 6: consecutive high samples needed to declare a key down.
- `HOLD_CYCLES`, 95: cycles a key must stay down before LONG is posted (0.5 s).
- `REPEAT_CYCLES`, 19: period between REPEAT events after LONG (0.1 s).

Ports:
- `clk190hz` in 1: scan clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `press` in N_KEYS: raw, bouncy button levels; bit k is key k.
- `ev_ready` in 1: consumer accepts the event this cycle.
- `clr_ovf` in 1: synchronous clear of all `ovf` bits.
- `ev_valid` out 1: event present.
- `ev_key` out clog2(N_KEYS): index of the key that produced the event.
- `ev_kind` out 2: event kind; 0 = PRESS, 1 = LONG, 2 = REPEAT, 3 = RELEASE.
- `ovf` out N_KEYS: sticky flag per key; set when that key's pending event was overwritten.
- `key_down` out N_KEYS: debounced key levels.

## Operation
- **Debounce (per key).**
  - Shift `press[k]` into a `STABLE_CYCLES`-bit history every cycle.
  - `key_down[k]` is 1 iff every history bit is 1; any 0 drops it immediately.
  - Reset clears the history.
- **Key FSM (per key)**, with a cycle counter wide enough for `max(HOLD_CYCLES, REPEAT_CYCLES)`:
  - IDLE: `key_down`=1 → DOWN; post PRESS; counter=0.
  - DOWN: counter++. When counter reaches `HOLD_CYCLES`-1 → HELD; post LONG; counter=0.
  - HELD: counter++. When counter reaches `REPEAT_CYCLES`-1 → post REPEAT; counter=0; stay in HELD.
  - From DOWN or HELD: `key_down`=0 → IDLE; post RELEASE. Release takes priority over any LONG/REPEAT due in the same cycle.
- **Pending slot (per key).** Each key has a 1-deep slot holding {full, kind}.
  - A post into an empty slot fills it.
  - A post into a full slot that is not being granted this cycle overwrites the kind and sets `ovf[k]`.
  - Grant and post in the same cycle: the granted (old) kind goes out, the slot holds the new kind, and `ovf` is not set.
- **Output register.**
  - Loads when it is empty, or when `ev_valid && ev_ready` this cycle.
  - On load, the arbiter grants the first full slot scanning from `ptr` upward (modulo `N_KEYS`). That slot clears, and `ptr` becomes grantee+1.
  - If no slot is full, `ev_valid` goes to 0.
  - While `ev_valid` && !`ev_ready`, `ev_key` and `ev_kind` hold stable.
- **`clr_ovf`.** Clears all `ovf` bits. A set in the same cycle wins.

## Timing
- Reset values:
  - `ev_valid`=0, `ev_key`=0, `ev_kind`=0, `ovf`=0, `key_down`=0.
  - All FSMs in IDLE, all slots empty, `ptr`=0.
- Reset asserted mid-event discards pending slots and the output register. No events are generated by keys that are held through reset deassertion until `STABLE_CYCLES` fresh high samples have been taken.
- Press latency, counting edge 1 as the first edge sampling `press[k]`=1 in an uninterrupted run:
  - `key_down[k]` rises after edge `STABLE_CYCLES`.
  - The slot fills after edge `STABLE_CYCLES`+1.
  - `ev_valid` rises after edge `STABLE_CYCLES`+2, if the output is free and no other key wins.
- LONG is posted `HOLD_CYCLES` cycles after PRESS is posted. Subsequent REPEATs are posted every `REPEAT_CYCLES` cycles.
- Release latency: `key_down` falls after the first edge sampling 0. RELEASE is posted on the next edge.
- Throughput: one event per cycle when `ev_ready` is held high.

## Structure
- Shared package `key_pkg`:
  - Event-kind constants `EV_PRESS`, `EV_LONG`, `EV_REPEAT`, `EV_RELEASE` (2-bit).
  - Default timing constants at 190 Hz.
- One sub-module, `key_filter`: debounce history plus the key FSM, counter and pending slot. It is instantiated `N_KEYS` times via generate.
- The round-robin arbiter and output register live in the top level.

## Test plan
- **Clean press:** `press[2]` high for 10 cycles then low, `ev_ready`=1, defaults.
  - `ev_valid` with key 2 / PRESS after edge 8.
  - RELEASE appears 2 edges after the first low sample.
  - No other events.
- **Bounce:** `press[0]` pattern 1,1,0,1,1,1,1,0 repeating.
  - `key_down[0]` never rises and no events occur.
  - Then holding high for 6 samples produces exactly one PRESS.
- **Long/repeat:** hold key 1 for 140 cycles after `key_down`.
  - Sequence PRESS, LONG 95 cycles later, then REPEAT every 19 cycles (2 REPEATs), then RELEASE.
- **Arbitration:** keys 0, 1, 3 become debounced in the same cycle, `ev_ready`=1.
  - Events are PRESS for keys 0, 1, 3 on consecutive cycles.
  - A next simultaneous burst starts from key 0 again only after `ptr` wraps.
- **Backpressure/overflow:** `ev_ready`=0 while key 0 produces PRESS then RELEASE.
  - The output holds key 0 / PRESS stable.
  - The slot's queued RELEASE is overwritten by a following PRESS and sets `ovf[0]`=1.
  - `clr_ovf` clears it.
- **Reset mid-hold:** assert `rst` while key 2 is in HELD with `ev_valid`=1.
  - All outputs return to 0 immediately.
  - After release of `rst` with `press[2]` still high, PRESS reappears 8 edges later.
